// File: rtl/mesh_dma_pkg.sv
// Shared types and constants for the mesh DMA responder.
package mesh_dma_pkg;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;
  localparam int unsigned RESP_DATA_W      = 32;
  localparam logic [31:0] ERR_DATA         = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                   v;
    logic [RESP_DATA_W-1:0] data;
  } resp_stage_t;

  // Keeps an out-of-range latency parameter from building a zero-depth pipe.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mesh_dma_resp_pipe.sv
// Fixed-depth valid/data shift register; latency depth_p cycles.
// Global hold freezes every stage, so nothing is dropped or duplicated.
module mesh_dma_resp_pipe
  import mesh_dma_pkg::*;
#(
  parameter int unsigned depth_p = 2,
  parameter type         stage_t = resp_stage_t
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_hold,
  input  stage_t i_stage,
  output stage_t o_stage
);

  stage_t r_stage [depth_p];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < depth_p; i++) r_stage[i] <= '0;
    end else if (!i_hold) begin
      r_stage[0] <= i_stage;
      for (int i = 1; i < depth_p; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_stage = r_stage[depth_p-1];

endmodule

// File: rtl/mesh_dma_responder.sv
// Mesh remote load/store responder: one in-order response per request, read_latency_p cycles,
// mem_stall_i freezes everything. Optional counters under MESH_DMA_RESP_PERF_EN.
module mesh_dma_responder
  import mesh_dma_pkg::*;
#(
  parameter int unsigned             data_width_p     = 32,
  parameter int unsigned             addr_width_p     = 12,
  parameter int unsigned             mem_addr_width_p = 10,
  parameter int unsigned             read_latency_p   = 2,
  parameter logic [data_width_p-1:0] err_data_p       = ERR_DATA
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      in_v_i,
  output logic                      in_yumi_o,
  input  logic                      in_we_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [data_width_p/8-1:0] in_mask_i,
  input  logic                      mem_stall_i,
  output logic                      returning_v_o,
  output logic [data_width_p-1:0]   returning_data_o,
  output logic                      err_o,
`ifdef MESH_DMA_RESP_PERF_EN
  output logic [31:0]               perf_loads_o,
  output logic [31:0]               perf_stores_o,
  output logic [31:0]               perf_stall_o,
`endif
  input  logic                      err_clr_i
);

  localparam int unsigned LAT    = clamp_latency(read_latency_p);
  localparam int unsigned MASK_W = data_width_p / 8;

  typedef struct packed {
    logic                    v;
    logic [data_width_p-1:0] data;
  } stage_t;

  logic [data_width_p-1:0]     r_mem [2**mem_addr_width_p];
  logic                        r_err;
  logic                        w_accept;
  logic                        w_in_range;
  logic                        w_wr_en;
  logic [mem_addr_width_p-1:0] w_mem_addr;
  stage_t                      w_stage_in;
  stage_t                      w_stage_out;

  assign w_accept   = in_v_i & ~mem_stall_i & reset_n_i;
  assign in_yumi_o  = w_accept;
  assign w_mem_addr = in_addr_i[mem_addr_width_p-1:0];

  generate
    if (addr_width_p > mem_addr_width_p) begin : g_range_chk
      assign w_in_range = (in_addr_i[addr_width_p-1:mem_addr_width_p] == '0);
    end else begin : g_range_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  assign w_wr_en = w_accept & in_we_i & w_in_range;

  // Contents are deliberately not reset; a read issued the cycle after a write sees the new bytes.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (in_mask_i[b]) r_mem[w_mem_addr][8*b +: 8] <= in_data_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_stage_in   = '0;
    w_stage_in.v = w_accept;
    if (w_accept && !in_we_i) begin
      w_stage_in.data = w_in_range ? r_mem[w_mem_addr] : err_data_p;
    end
  end

  // A new error beats a simultaneous clear so it is never lost.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign err_o = r_err;

  mesh_dma_resp_pipe #(
    .depth_p (LAT),
    .stage_t (stage_t)
  ) u_resp_pipe (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_hold  (mem_stall_i),
    .i_stage (w_stage_in),
    .o_stage (w_stage_out)
  );

  assign returning_v_o    = w_stage_out.v & ~mem_stall_i;
  assign returning_data_o = w_stage_out.data;

`ifdef MESH_DMA_RESP_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_stall  <= '0;
    end else if (err_clr_i) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_accept && !in_we_i) r_perf_loads  <= r_perf_loads + 32'd1;
      if (w_accept && in_we_i)  r_perf_stores <= r_perf_stores + 32'd1;
      if (in_v_i && mem_stall_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_loads_o  = r_perf_loads;
  assign perf_stores_o = r_perf_stores;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_mesh_dma_responder.sv
// Directed self-checking bench for mesh_dma_responder (default parameters, latency 2).
module tb_mesh_dma_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_v = 1'b0;
  logic        in_we = 1'b0;
  logic        stall = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic        yumi;
  logic        rv;
  logic        err;
  logic [31:0] rdata;
`ifdef MESH_DMA_RESP_PERF_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [31:0] rsp_q [$];
  int          rsp_cyc [$];

  mesh_dma_responder dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .in_v_i           (in_v),
    .in_yumi_o        (yumi),
    .in_we_i          (in_we),
    .in_addr_i        (addr),
    .in_data_i        (wdata),
    .in_mask_i        (mask),
    .mem_stall_i      (stall),
    .returning_v_o    (rv),
    .returning_data_o (rdata),
    .err_o            (err),
`ifdef MESH_DMA_RESP_PERF_EN
    .perf_loads_o     (perf_loads),
    .perf_stores_o    (perf_stores),
    .perf_stall_o     (perf_stall),
`endif
    .err_clr_i        (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every emitted response is logged with the cycle it appeared in.
  always @(negedge clk) begin
    if (rv) begin
      rsp_q.push_back(rdata);
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] m, output int acc);
    in_v  = 1'b1;
    in_we = we;
    addr  = a;
    wdata = d;
    mask  = m;
    acc   = cyc;
    #1 chk("yumi", {31'd0, yumi}, 32'd1);
    tick();
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    in_v = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [31:0] getq(input int i);
    return (i < rsp_q.size()) ? rsp_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int getc(input int i);
    return (i < rsp_cyc.size()) ? rsp_cyc[i] : -100;
  endfunction

  task automatic clear_q();
    rsp_q.delete();
    rsp_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int dummy;

    // Reset state, with a request presented to confirm accept is gated.
    reset_n = 1'b0;
    in_v    = 1'b1;
    tick();
    chk("rst_yumi",  {31'd0, yumi}, 32'd0);
    chk("rst_rv",    {31'd0, rv},   32'd0);
    chk("rst_rdata", rdata,         32'd0);
    chk("rst_err",   {31'd0, err},  32'd0);
    in_v = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Store then load same address on the next cycle.
    clear_q();
    req(1'b1, 12'd5, 32'h1234_5678, 4'hF, a0);
    req(1'b0, 12'd5, 32'h0, 4'h0, dummy);
    idle(4);
    chk("a_count",   rsp_q.size(),    32'd2);
    chk("a_st_data", getq(0),         32'h0);
    chk("a_st_lat",  getc(0) - a0,    32'd2);
    chk("a_ld_data", getq(1),         32'h1234_5678);
    chk("a_ld_lat",  getc(1) - a0,    32'd3);

    // Partial byte mask over zero, then an all-zero mask that must not write.
    clear_q();
    req(1'b1, 12'd7, 32'h0,         4'hF,    dummy);
    req(1'b1, 12'd7, 32'hAABB_CCDD, 4'b0101, dummy);
    req(1'b0, 12'd7, 32'h0,         4'h0,    dummy);
    req(1'b1, 12'd7, 32'hFFFF_FFFF, 4'h0,    dummy);
    req(1'b0, 12'd7, 32'h0,         4'h0,    dummy);
    idle(4);
    chk("b_count",    rsp_q.size(), 32'd5);
    chk("b_mask_ld",  getq(2),      32'h00BB_00DD);
    chk("b_mask0_st", getq(3),      32'h0);
    chk("b_mask0_ld", getq(4),      32'h00BB_00DD);

    // Out-of-range traffic: dropped store, error data, sticky flag, set beats clear.
    clear_q();
    req(1'b1, 12'd0,   32'h1111_1111, 4'hF, dummy);
    req(1'b1, 12'h400, 32'h2222_2222, 4'hF, dummy);
    chk("c_err_st", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("c_err_clr", {31'd0, err}, 32'd0);
    req(1'b0, 12'd0,   32'h0, 4'h0, dummy);
    req(1'b0, 12'h400, 32'h0, 4'h0, dummy);
    chk("c_err_ld", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    req(1'b0, 12'h401, 32'h0, 4'h0, dummy);
    err_clr = 1'b0;
    chk("c_err_set_wins", {31'd0, err}, 32'd1);
    idle(4);
    chk("c_count",    rsp_q.size(), 32'd5);
    chk("c_alias_ld", getq(2),      32'h1111_1111);
    chk("c_oob_ld",   getq(3),      32'hDEAD_BEEF);
    chk("c_oob_ld2",  getq(4),      32'hDEAD_BEEF);

    // Eight back-to-back loads with a 3-cycle stall in the middle.
    for (int i = 0; i < 8; i++) req(1'b1, 12'(16 + i), 32'hC0DE_0000 + 32'(i), 4'hF, dummy);
    idle(3);
    clear_q();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        in_v  = 1'b1;
        in_we = 1'b0;
        addr  = 12'(16 + i);
        stall = 1'b1;
        repeat (3) begin
          #1;
          chk("d_stall_yumi", {31'd0, yumi}, 32'd0);
          chk("d_stall_rv",   {31'd0, rv},   32'd0);
          tick();
        end
        stall = 1'b0;
      end
      req(1'b0, 12'(16 + i), 32'h0, 4'h0, dummy);
    end
    idle(5);
    chk("d_count", rsp_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("d_order%0d", i), getq(i), 32'hC0DE_0000 + 32'(i));

    // Reset with two responses in flight.
    clear_q();
    req(1'b0, 12'h400, 32'h0, 4'h0, dummy);
    req(1'b0, 12'd1,   32'h0, 4'h0, dummy);
    reset_n = 1'b0;
    #1 chk("e_rv_in_rst", {31'd0, rv}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    idle(5);
    chk("e_count", rsp_q.size(),  32'd0);
    chk("e_err",   {31'd0, err},  32'd0);
    chk("e_rv",    {31'd0, rv},   32'd0);

`ifdef MESH_DMA_RESP_PERF_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) req(1'b0, 12'd1, 32'h0, 4'h0, dummy);
    for (int i = 0; i < 2; i++) req(1'b1, 12'd2, 32'h5, 4'hF, dummy);
    in_v  = 1'b1;
    in_we = 1'b0;
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    in_v  = 1'b0;
    tick();
    chk("p_loads",  perf_loads,  32'd3);
    chk("p_stores", perf_stores, 32'd2);
    chk("p_stall",  perf_stall,  32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
